// File: rtl/jtframe_rom_nslot.sv
// N-slot ROM arbiter: per-slot one-word caches in front of a shared SDRAM read port.
// Latency: cache hits are combinational (0 cycles); a miss costs grant, SDRAM ack/data time, then 1 cycle.
// Backpressure: sdram_req holds until sdram_ack; slots keep slot_ok low until their word is cached.
module jtframe_rom_nslot #(
    parameter int                  SLOTS   = 4,
    parameter int                  AW      = 22,
    parameter logic [SLOTS*22-1:0] OFFSETS = {SLOTS{22'd0}},
    parameter logic [SLOTS-1:0]    DW16    = {SLOTS{1'b0}},
    parameter bit                  RR      = 1'b0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*16-1:0] slot_dout,
    output logic                sdram_req,
    output logic [21:0]         sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);
    // Tags are stored at the 16-bit width; 8-bit slots zero-extend their shorter tag.
    localparam int TW = AW - 1;
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;

    logic [31:0]      cache_dat [SLOTS];
    logic [TW-1:0]    cache_tag [SLOTS];
    logic [SLOTS-1:0] cache_vld;

    logic [AW-1:0]    addr_i    [SLOTS];
    logic [TW-1:0]    cur_tag   [SLOTS];
    logic [21:0]      cur_sdram [SLOTS];
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] miss;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win_idx;
    logic             win_found;
    logic [SW-1:0]    scan_idx;
    logic [IW-1:0]    lat_idx;
    logic [TW-1:0]    lat_tag;

    // Per-slot tag, SDRAM word address and hit/miss decode.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_i[i] = slot_addr[i*AW +: AW];
            if (DW16[i]) begin
                cur_tag[i] = addr_i[i][AW-1:1];
            end else begin
                cur_tag[i] = {1'b0, addr_i[i][AW-1:2]};
            end
            // 32-bit fetches always start on an even 16-bit word; the sum wraps at 22 bits.
            cur_sdram[i] = OFFSETS[i*22 +: 22] + 22'({cur_tag[i], 1'b0});
            hit[i]  = slot_cs[i] & cache_vld[i] & (cache_tag[i] == cur_tag[i]) & ~downloading;
            miss[i] = slot_cs[i] & ~hit[i] & ~downloading;
        end
    end

    assign slot_ok    = hit;
    assign refresh_en = (state == IDLE) & ~|miss;

    // Half/byte selection out of each slot's cached 32-bit word.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slot_dout[i*16 +: 16] = 16'h0000;
            if (DW16[i]) begin
                slot_dout[i*16 +: 16] = addr_i[i][0] ? cache_dat[i][31:16] : cache_dat[i][15:0];
            end else begin
                case (addr_i[i][1:0])
                    2'd0:    slot_dout[i*16 +: 16] = {8'h00, cache_dat[i][7:0]};
                    2'd1:    slot_dout[i*16 +: 16] = {8'h00, cache_dat[i][15:8]};
                    2'd2:    slot_dout[i*16 +: 16] = {8'h00, cache_dat[i][23:16]};
                    default: slot_dout[i*16 +: 16] = {8'h00, cache_dat[i][31:24]};
                endcase
            end
        end
    end

    // Winner search: from slot 0 (fixed priority) or from the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < SLOTS; k++) begin
            scan_idx = (RR ? {1'b0, rr_ptr} : SW'(0)) + SW'(k);
            if (scan_idx >= SW'(SLOTS)) begin
                scan_idx = scan_idx - SW'(SLOTS);
            end
            if (!win_found && miss[scan_idx[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IW-1:0];
            end
        end
    end

    // Request FSM plus cache fill; the fill uses the tag latched at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= 22'd0;
            rr_ptr     <= '0;
            lat_idx    <= '0;
            lat_tag    <= '0;
            cache_vld  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                cache_dat[i] <= 32'd0;
                cache_tag[i] <= '0;
            end
        end else begin
            if (downloading) begin
                cache_vld <= '0;
            end
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_idx    <= win_idx;
                        lat_tag    <= cur_tag[win_idx];
                        sdram_addr <= cur_sdram[win_idx];
                        sdram_req  <= 1'b1;
                        rr_ptr     <= (win_idx == IW'(SLOTS - 1)) ? '0 : win_idx + 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        cache_dat[lat_idx] <= data_read;
                        cache_tag[lat_idx] <= lat_tag;
                        // A word fetched across a download is stale: keep it invalid.
                        cache_vld[lat_idx] <= ~downloading;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
